// File: rtl/dmi_req_sync_multi.sv
// dmi_req_sync_multi: carries NUM_CH level-toggled requests from the TCK
// domain into the core clock domain. Each channel has a SYNC_STAGES-deep
// synchroniser, selectable edge detection and a payload captured on the
// detected edge. The request is then held under valid/ready until the core
// accepts it, with a sticky overrun flag. A post-reset warm-up masks the
// spurious edges seen while the synchroniser chain fills.
module dmi_req_sync_multi #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        async_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_ready,
    output logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ovr,
    input  logic [NUM_CH-1:0]        ovr_clr,
    output logic [NUM_CH-1:0]        sync_out,
    output logic                     warm
);

    localparam int              CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_VAL = CNT_W'(SYNC_STAGES + 1);

    logic [NUM_CH-1:0]        sync_p [SYNC_STAGES];
    logic [NUM_CH-1:0]        hist_p;
    logic [CNT_W-1:0]         warm_cnt;
    logic [NUM_CH-1:0]        rise;
    logic [NUM_CH-1:0]        fall;
    logic [NUM_CH-1:0]        det;
    logic [NUM_CH-1:0]        qdet;
    logic [NUM_CH-1:0]        valid_nxt;
    logic [NUM_CH-1:0]        ovr_nxt;
    logic [NUM_CH*DATA_W-1:0] data_nxt;

    generate
        if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
            $error("dmi_req_sync_multi: EDGE_MODE must be 0, 1 or 2");
        end
    endgenerate

    // Synchroniser chain per channel plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
            hist_p <= '0;
        end else begin
            sync_p[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
            hist_p <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];

    // Warm-up counter: saturates once the chain holds only post-reset samples
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_VAL) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    assign warm = (warm_cnt == WARM_VAL);

    // Edge selection on the synchronised level, masked until warm
    always_comb begin
        rise = sync_p[SYNC_STAGES-1] & ~hist_p;
        fall = ~sync_p[SYNC_STAGES-1] & hist_p;
        case (EDGE_MODE)
            0:       det = rise;
            1:       det = fall;
            default: det = rise | fall;
        endcase
        qdet = det & {NUM_CH{warm}};
    end

    // Per-channel handshake: load/reload beats overrun beats plain accept
    always_comb begin
        valid_nxt = req_valid;
        data_nxt  = req_data;
        ovr_nxt   = req_ovr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (qdet[i] && (!req_valid[i] || req_ready[i])) begin
                valid_nxt[i]                    = 1'b1;
                data_nxt[i*DATA_W +: DATA_W]    = data_in[i*DATA_W +: DATA_W];
            end else if (!qdet[i] && req_valid[i] && req_ready[i]) begin
                valid_nxt[i] = 1'b0;
            end
            // a new edge on a still-pending request wins over the clear
            if (qdet[i] && req_valid[i] && !req_ready[i]) begin
                ovr_nxt[i] = 1'b1;
            end else if (ovr_clr[i]) begin
                ovr_nxt[i] = 1'b0;
            end
        end
    end

    // Request, payload and overrun registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid <= '0;
            req_data  <= '0;
            req_ovr   <= '0;
        end else begin
            req_valid <= valid_nxt;
            req_data  <= data_nxt;
            req_ovr   <= ovr_nxt;
        end
    end

endmodule

// File: tb/tb_dmi_req_sync_multi.sv
// Bench for dmi_req_sync_multi: three instances share stimulus
// (A: S=2 rising, B: S=2 both edges, C: S=3 falling); each vector names
// which instance its expectations apply to.
module tb_dmi_req_sync_multi;

    typedef struct {
        logic        rst;
        logic [1:0]  a;
        logic [31:0] d1;
        logic [31:0] d0;
        logic [1:0]  rdy;
        logic [1:0]  clr;
        logic [1:0]  e_vld;
        logic [31:0] e_d1;
        logic [31:0] e_d0;
        logic [1:0]  e_ovr;
        logic        e_warm;
        logic [1:0]  e_sync;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  async_in;
    logic [63:0] data_in;
    logic [1:0]  req_ready;
    logic [1:0]  ovr_clr;

    logic [1:0]  vld  [3];
    logic [63:0] dat  [3];
    logic [1:0]  ovr  [3];
    logic [1:0]  sync [3];
    logic        wrm  [3];

    int   checks = 0;
    int   errors = 0;
    string tag;
    vec_t tbl [$];
    vec_t sb  [$];

    always #5 clk = ~clk;

    dmi_req_sync_multi #(.NUM_CH(2), .DATA_W(32), .SYNC_STAGES(2), .EDGE_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .async_in(async_in), .data_in(data_in),
        .req_valid(vld[0]), .req_ready(req_ready), .req_data(dat[0]),
        .req_ovr(ovr[0]), .ovr_clr(ovr_clr), .sync_out(sync[0]), .warm(wrm[0]));

    dmi_req_sync_multi #(.NUM_CH(2), .DATA_W(32), .SYNC_STAGES(2), .EDGE_MODE(2)) dut_b (
        .clk(clk), .rst(rst), .async_in(async_in), .data_in(data_in),
        .req_valid(vld[1]), .req_ready(req_ready), .req_data(dat[1]),
        .req_ovr(ovr[1]), .ovr_clr(ovr_clr), .sync_out(sync[1]), .warm(wrm[1]));

    dmi_req_sync_multi #(.NUM_CH(2), .DATA_W(32), .SYNC_STAGES(3), .EDGE_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .async_in(async_in), .data_in(data_in),
        .req_valid(vld[2]), .req_ready(req_ready), .req_data(dat[2]),
        .req_ovr(ovr[2]), .ovr_clr(ovr_clr), .sync_out(sync[2]), .warm(wrm[2]));

    function automatic vec_t mk(logic r, logic [1:0] a, logic [31:0] d1, logic [31:0] d0,
                                logic [1:0] rdy, logic [1:0] clr, logic [1:0] e_vld,
                                logic [31:0] e_d1, logic [31:0] e_d0, logic [1:0] e_ovr,
                                logic e_warm, logic [1:0] e_sync);
        vec_t v;
        v.rst = r; v.a = a; v.d1 = d1; v.d0 = d0; v.rdy = rdy; v.clr = clr;
        v.e_vld = e_vld; v.e_d1 = e_d1; v.e_d0 = e_d0; v.e_ovr = e_ovr;
        v.e_warm = e_warm; v.e_sync = e_sync;
        return v;
    endfunction

    task automatic chk(string f, int idx, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] %s got=%h exp=%h", tag, idx, f, got, exp);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the edge.
    task automatic apply(vec_t v, int sel, int idx);
        vec_t e;
        rst       = v.rst;
        async_in  = v.a;
        data_in   = {v.d1, v.d0};
        req_ready = v.rdy;
        ovr_clr   = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("req_valid", idx, 32'(vld[sel]), 32'(e.e_vld));
        chk("req_data0", idx, dat[sel][31:0], e.e_d0);
        chk("req_data1", idx, dat[sel][63:32], e.e_d1);
        chk("req_ovr", idx, 32'(ovr[sel]), 32'(e.e_ovr));
        chk("warm", idx, 32'(wrm[sel]), 32'(e.e_warm));
        chk("sync_out", idx, 32'(sync[sel]), 32'(e.e_sync));
    endtask

    task automatic run_tbl(int sel);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], sel, i);
        end
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst = 1'b1; async_in = '0; data_in = '0; req_ready = '0; ovr_clr = '0;

        // A: warm-up with level high through reset, then latency and accept
        tag = "warm_latency";
        //            rst a      d1  d0            rdy    clr    vld    ed1 ed0           ovr    w     sync
        tbl.push_back(mk(1, 2'b01, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b01, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b01, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b0, 2'b01));
        tbl.push_back(mk(0, 2'b01, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b01, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b00, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b00, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0, 0,            2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12345678, 2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12345678, 2'b00, 2'b00, 2'b00, 0, 0,            2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12345678, 2'b00, 2'b00, 2'b01, 0, 32'h12345678, 2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12345678, 2'b01, 2'b00, 2'b00, 0, 32'h12345678, 2'b00, 1'b1, 2'b01));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12345678, 2'b00, 2'b00, 2'b00, 0, 32'h12345678, 2'b00, 1'b1, 2'b01));
        run_tbl(0);

        // B: overrun, clear-vs-set, then accept-plus-reload on channel 1
        tag = "ovr_reload";
        tbl.push_back(mk(1, 2'b00, 0,            0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0,            0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0,            0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0,            0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b10, 32'h0000CAFE, 0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b10, 32'h0000CAFE, 0, 2'b00, 2'b00, 2'b00, 0,            0, 2'b00, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b10, 32'h0000CAFE, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 32'h0000BEEF, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 32'h0000BEEF, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 32'h0000BEEF, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b10, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b10, 32'h0000BEEF, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b10, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b10, 32'h0000BEEF, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b10, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b10, 32'h0000BEEF, 0, 2'b00, 2'b10, 2'b10, 32'h0000CAFE, 0, 2'b10, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b10, 32'h0000BEEF, 0, 2'b00, 2'b10, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 32'h00001111, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 32'h00001111, 0, 2'b00, 2'b00, 2'b10, 32'h0000CAFE, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 32'h00001111, 0, 2'b10, 2'b00, 2'b10, 32'h00001111, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 32'h00001111, 0, 2'b10, 2'b00, 2'b00, 32'h00001111, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 32'h00001111, 0, 2'b00, 2'b00, 2'b00, 32'h00001111, 0, 2'b00, 1'b1, 2'b00));
        run_tbl(1);

        // C: S=3 falling mode; rising ignored, both channels fall together
        tag = "fall_s3";
        tbl.push_back(mk(1, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b11, 32'hB1B1B1B1, 32'hA0A0A0A0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b11, 32'hB1B1B1B1, 32'hA0A0A0A0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b11, 32'hB1B1B1B1, 32'hA0A0A0A0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b11));
        tbl.push_back(mk(0, 2'b11, 32'hB1B1B1B1, 32'hA0A0A0A0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b11));
        tbl.push_back(mk(0, 2'b11, 32'hB1B1B1B1, 32'hA0A0A0A0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b11));
        tbl.push_back(mk(0, 2'b00, 32'hD1D1D1D1, 32'hC0C0C0C0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b11));
        tbl.push_back(mk(0, 2'b00, 32'hD1D1D1D1, 32'hC0C0C0C0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b11));
        tbl.push_back(mk(0, 2'b00, 32'hD1D1D1D1, 32'hC0C0C0C0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 32'hD1D1D1D1, 32'hC0C0C0C0, 2'b00, 2'b00, 2'b11, 32'hD1D1D1D1, 32'hC0C0C0C0, 2'b00, 1'b1, 2'b00));
        run_tbl(2);

        // B: reset while a request and its overrun are pending
        tag = "mid_reset";
        apply(mk(1, 2'b00, 0,     0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b00), 1, 0);
        apply(mk(0, 2'b00, 0,     0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b00), 1, 1);
        apply(mk(0, 2'b00, 0,     0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b00), 1, 2);
        apply(mk(0, 2'b00, 0,     0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b00), 1, 3);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b00), 1, 4);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b10), 1, 5);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b10, 32'h55, 0, 2'b00, 1'b1, 2'b10), 1, 6);
        apply(mk(0, 2'b00, 32'h55, 0, 2'b00, 2'b00, 2'b10, 32'h55, 0, 2'b00, 1'b1, 2'b10), 1, 7);
        apply(mk(0, 2'b00, 32'h55, 0, 2'b00, 2'b00, 2'b10, 32'h55, 0, 2'b00, 1'b1, 2'b00), 1, 8);
        apply(mk(0, 2'b00, 32'h55, 0, 2'b00, 2'b00, 2'b10, 32'h55, 0, 2'b10, 1'b1, 2'b00), 1, 9);
        apply(mk(1, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b00), 1, 10);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b00), 1, 11);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b0, 2'b10), 1, 12);
        apply(mk(0, 2'b10, 32'h55, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b10), 1, 13);
        apply(mk(0, 2'b00, 32'h77, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b10), 1, 14);
        apply(mk(0, 2'b00, 32'h77, 0, 2'b00, 2'b00, 2'b00, 0,     0, 2'b00, 1'b1, 2'b00), 1, 15);
        apply(mk(0, 2'b00, 32'h77, 0, 2'b00, 2'b00, 2'b10, 32'h77, 0, 2'b00, 1'b1, 2'b00), 1, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmi_req_sync_multi.md
Name: dmi_req_sync_multi

Overview:
Parametrised successor to the DMI JTAG-to-core request synchroniser. Carries NUM_CH independent level-toggled requests from the TCK domain into the core clock domain. Each channel has a SYNC_STAGES-deep synchroniser, configurable edge detection and a payload captured at detection. Each request is then held under a valid/ready handshake until the core accepts it, with overrun tracking and a post-reset warm-up that suppresses spurious edges. It sits between the DMI JTAG TAP logic and the core debug-module register interface.

Parameters:
NUM_CH, 2, number of independent request channels (>=1)
DATA_W, 32, payload width per channel (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both edges of the synchronised level

Ports:
clk  input  1  core clock
rst  input  1  reset: synchronous, active-high
async_in  input  NUM_CH  request levels from the TCK domain; asynchronous to clk
data_in  input  NUM_CH*DATA_W  payload; channel i uses slice [i*DATA_W +: DATA_W]; the source holds it stable from its async_in[i] toggle until req_valid[i] is seen low again
req_valid  output  NUM_CH  per-channel request pending toward the core
req_ready  input  NUM_CH  core accepts channel i when req_valid[i] & req_ready[i]
req_data  output  NUM_CH*DATA_W  captured payload, same slicing as data_in
req_ovr  output  NUM_CH  sticky: an edge arrived while the previous request was unaccepted
ovr_clr  input  NUM_CH  write-1-to-clear for req_ovr
sync_out  output  NUM_CH  synchronised level (last synchroniser stage)
warm  output  1  high once warm-up is complete

Behaviour:
- Reset (rst high at a clk edge): all synchroniser flops, history flops, req_valid, req_data, req_ovr and the warm-up counter go to 0; warm = 0; sync_out = 0.
- Per channel: stages s[0..S-1] with S = SYNC_STAGES; s[0] <= async_in[i]; s[k] <= s[k-1]. History flop h <= s[S-1]. sync_out[i] = s[S-1].
- Raw edge: rise = s[S-1] & ~h; fall = ~s[S-1] & h; det = rise (mode 0), fall (mode 1), rise | fall (mode 2). Any other EDGE_MODE value is an elaboration error.
- Warm-up: counter of width clog2(S+2) increments every cycle after reset and saturates at S+1. warm = (counter == S+1). Qualified edge qdet = det & warm. Edges before warm are discarded entirely: no valid, no overrun.
- Latency: a level change sampled into s[0] at clk edge n is visible as req_valid high after clk edge n+S.
- Handshake per channel, priority order:
  - qdet & (~req_valid | req_ready): req_valid <= 1, req_data slice <= data_in slice. This covers accept and reload in the same cycle; no overrun.
  - qdet & req_valid & ~req_ready: req_valid stays 1; req_data keeps the OLD value; req_ovr <= 1.
  - ~qdet & req_valid & req_ready: req_valid <= 0; req_data holds its value.
- req_ovr: set as above. Otherwise cleared by ovr_clr[i] = 1. Set and clear in the same cycle leaves req_ovr = 1 (set wins).
- req_data is stable whenever req_valid is high and not being reloaded.
- req_ready while req_valid = 0 is ignored.
- Channels are fully independent; simultaneous edges on several channels all register in the same cycle.
- Reset mid-handshake drops any pending request and its overrun flag, and restarts warm-up.
- All outputs are registered except warm, which is decoded from the counter register.

Test Plan:
- Warm-up, S=2, mode 0: async_in[0] = 1 held through reset, release rst -> req_valid[0] stays 0 forever, warm high after 3 edges, sync_out[0] = 1 after 2 edges.
- Latency: after warm, drive async_in[0] 0->1 with data_in slice 0x1234_5678 before edge n -> req_valid[0] = 1 after edge n+2, req_data = 0x1234_5678; hold req_ready = 1 for one cycle -> req_valid[0] = 0 on the next edge.
- Overrun, mode 2, req_ready = 0: toggle async_in[1] 0->1, then 1->0 later with data changed to 0xBEEF -> req_valid stays 1, req_data keeps the first payload, req_ovr[1] = 1. Assert ovr_clr[1] and a new qdet in the same cycle -> req_ovr[1] stays 1. ovr_clr[1] alone -> req_ovr[1] = 0.
- Accept-plus-reload: qdet coincident with req_valid & req_ready -> req_valid stays 1, req_data updates to the new payload, req_ovr unchanged (0).
- Mode 1 with S=3: rising edge -> no request; falling edge -> req_valid after 3 edges; channels 0 and 1 falling in the same cycle -> both valid in the same cycle.
- Mid-operation reset: rst pulsed while req_valid = 1 and req_ovr = 1 -> both 0 on the next edge, warm = 0, and no request for S+1 cycles even if async_in toggles.
